// File: rtl/fifo_pkg.sv
// Shared FIFO constants and helpers: count width, default thresholds,
// and parameter sanity checks reused by FIFO blocks.
package fifo_pkg;

   localparam int AE_DEFAULT = 2;

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int af_default(input int depth);
      return depth - 2;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// FIFO bus bundle: write/read requests, data and status flags.
// master = requester side, slave = FIFO side.
interface sync_fifo_flags_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   localparam int CNT_W     = cnt_w(DEPTH)
);

   logic                  w_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  r_en;
   logic                  clr_err;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  rd_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [CNT_W-1:0]      count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output w_en, data_in, r_en, clr_err,
      input  data_out, rd_valid, full, empty,
      input  almost_full, almost_empty, count,
      input  overflow, underflow
   );

   modport slave (
      input  w_en, data_in, r_en, clr_err,
      output data_out, rd_valid, full, empty,
      output almost_full, almost_empty, count,
      output overflow, underflow
   );

endinterface

// File: rtl/sfifo_ram.sv
// Simple dual-port storage: synchronous write, registered read.
// Ports: we/waddr/wdata write side; re/raddr -> rdata (1-cycle latency).
module sfifo_ram #(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   // Storage is intentionally not reset; only the output register is.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Holds its value when no read is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, level flags and sticky errors.
// Ports: clk, rst_n, w_en/data_in, r_en -> data_out/rd_valid, flags, count.
module sync_fifo_flags
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int AF_THRESH  = af_default(DEPTH),
   parameter int AE_THRESH  = AE_DEFAULT,
   localparam int CNT_W     = cnt_w(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  w_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  r_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [CNT_W-1:0]      count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err
);

   localparam int AW = $clog2(DEPTH);

   if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
      $fatal(1, "sync_fifo_flags: DEPTH must be a power of two >= 4");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $fatal(1, "sync_fifo_flags: AF_THRESH out of range");
   end
   if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $fatal(1, "sync_fifo_flags: AE_THRESH out of range");
   end

   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          wr_acc;
   logic          rd_acc;

   // Acceptance depends only on registered flags, so a full FIFO
   // drops the write even when a read frees a slot that cycle.
   assign wr_acc = w_en && !full;
   assign rd_acc = r_en && !empty;

   // Flags are pure decodes of the registered count.
   assign full         = (count == CNT_W'(DEPTH));
   assign empty        = (count == '0);
   assign almost_full  = (count >= CNT_W'(AF_THRESH));
   assign almost_empty = (count <= CNT_W'(AE_THRESH));

   sfifo_ram #(
      .DW (DATA_WIDTH),
      .AW (AW)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_acc),
      .waddr (wptr),
      .wdata (data_in),
      .re    (rd_acc),
      .raddr (rptr),
      .rdata (data_out)
   );

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (wr_acc) wptr <= wptr + 1'b1;
         if (rd_acc) rptr <= rptr + 1'b1;
         rd_valid <= rd_acc;
         unique case (1'b1)
            (wr_acc && !rd_acc): count <= count + 1'b1;
            (rd_acc && !wr_acc): count <= count - 1'b1;
            default:             count <= count;
         endcase
      end
   end

   // A new error event takes priority over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (w_en && full) overflow <= 1'b1;
         else if (clr_err) overflow <= 1'b0;
         if (r_en && empty) underflow <= 1'b1;
         else if (clr_err)  underflow <= 1'b0;
      end
   end

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the number of storage entries; it SHALL be a power of two and at least 4.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2, meaning almost_full asserts when count >= AF_THRESH; valid range is 1..DEPTH.
REQ-004 SHALL have parameter AE_THRESH, default 2, meaning almost_empty asserts when count <= AE_THRESH; valid range is 0..DEPTH-1.
REQ-005 SHALL have parameter CNT_W, derived as $clog2(DEPTH)+1 and not overridable.
REQ-006 SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock; one clock; all logic on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- w_en  input  1  write request.
- data_in  input  DATA_WIDTH  write data.
- r_en  input  1  read request.
- data_out  output  DATA_WIDTH  registered read data.
- rd_valid  output  1  data_out holds a newly read word this cycle.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.
- clr_err  input  1  synchronous clear of overflow and underflow.

Function
REQ-007 SHALL accept a write iff w_en && !full; the accepted data is stored at the write pointer, and the write pointer increments modulo DEPTH.
REQ-008 SHALL accept a read iff r_en && !empty; data_out loads the head entry on that edge, rd_valid is 1 for the following cycle, and the read pointer increments modulo DEPTH; read latency is 1 cycle.
REQ-009 SHALL keep data_out unchanged and drive rd_valid 0 in any cycle with no accepted read.
REQ-010 SHALL update count as +1 for a write only, -1 for a read only, and unchanged for both or neither.
REQ-011 SHALL, when full with w_en && r_en both high, accept the read only and drop the write; the next cycle count = DEPTH-1 and overflow is set.
REQ-012 SHALL, when empty with w_en && r_en both high, accept the write only and block the read; the next cycle count = 1, rd_valid = 0, and underflow is set.
REQ-013 SHALL, when 0 < count < DEPTH with both requests high, accept both and keep count constant; the read returns the old head and never the word written in the same cycle.
REQ-014 SHALL derive full, empty, almost_full and almost_empty solely from the registered count, with no combinational path from w_en or r_en.
REQ-015 SHALL set overflow on w_en && full and underflow on r_en && empty; both hold until clr_err or reset, and a set event in the same cycle as clr_err wins.
REQ-016 SHALL wrap pointers seamlessly: no data corruption or flag glitch across the DEPTH-1 -> 0 wrap on either pointer.
REQ-017 SHALL never modify the storage location addressed by the read pointer when a write is rejected.

Reset
REQ-018 SHALL, on rst_n low at any time, asynchronously set pointers = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0, rd_valid = 0, data_out = 0.
REQ-019 SHALL discard all stored contents on reset mid-operation; storage array contents need not be cleared.
REQ-020 SHALL accept requests on the first rising clk edge after rst_n deasserts.

Structure
REQ-021 SHALL place the shared constants (CNT_W derivation, default thresholds) in package fifo_pkg, reused by future FIFO blocks.
REQ-022 SHALL instantiate the storage as sub-module sfifo_ram: a simple dual-port array with a synchronous write port and a registered read port, both on clk.
REQ-023 SHALL check parameters at elaboration (DEPTH power of two, thresholds in range) and fail elaboration if violated.

Verification (DEPTH=8, DATA_WIDTH=8, AF_THRESH=6, AE_THRESH=2)
REQ-024 SHALL cover: write 0x01..0x08 -> count 1..8; almost_empty drops after the 3rd write, almost_full rises after the 6th, full after the 8th; a 9th write of 0xFF -> overflow = 1 and count stays 8.
REQ-025 SHALL cover: 8 reads from full -> data_out 0x01..0x08 in order, each with rd_valid one cycle after r_en; empty after the 8th read; a further read -> underflow = 1 and data_out stays 0x08.
REQ-026 SHALL cover: with count = 4, simultaneous read and write for 20 cycles (data 0x10..0x23) -> count stays 4, output order is preserved across two pointer wraps, and no flag toggles.
REQ-027 SHALL cover: at full, w_en = r_en = 1 -> count 7, overflow = 1, the read returns the head; at empty, w_en = r_en = 1 -> count 1, underflow = 1, rd_valid = 0.
REQ-028 SHALL cover: overflow and underflow set, then clr_err pulsed for 1 cycle -> both 0; clr_err coincident with a new overflow event -> overflow remains 1.
REQ-029 SHALL cover: rst_n asserted mid-stream at count = 5 -> all outputs at reset values immediately, without waiting for a clk edge; after release, a write of 0xAA then a read -> data_out = 0xAA.
